// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the address-phase control bundle used by the
// memory arbiter and its per-master hold buffers.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Address-phase control; the address travels separately so its width can
  // follow the ADDR_W parameter of the users.
  typedef struct packed {
    logic       sel;
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } ahb_ctrl_t;
endpackage

// File: rtl/ahblite3_arb_hold.sv
// Per-master stall buffer: captures a NONSEQ address phase the slave did not
// take, and presents it as a NONSEQ replay until the slave accepts it.
module ahblite3_arb_hold
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  ahb_ctrl_t         live_ctrl,
  input  logic [ADDR_W-1:0] live_addr,
  input  logic              hready,
  input  logic              grant,
  input  logic              s_ready,
  output logic              req,
  output logic              pend,
  output ahb_ctrl_t         out_ctrl,
  output logic [ADDR_W-1:0] out_addr
);
  ahb_ctrl_t         hold_ctrl;
  logic [ADDR_W-1:0] hold_addr;
  logic              live_req, capture;

  assign live_req = live_ctrl.sel && (live_ctrl.trans == HTRANS_NONSEQ) && hready;
  // Anything the master believes issued but the slave did not take is kept.
  assign capture  = live_req && !pend && !(grant && s_ready);
  assign req      = live_req || pend;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend      <= 1'b0;
      hold_ctrl <= '0;
      hold_addr <= '0;
    end else if (capture) begin
      pend      <= 1'b1;
      hold_ctrl <= live_ctrl;
      hold_addr <= live_addr;
    end else if (pend && grant && s_ready) begin
      pend <= 1'b0;
    end
  end

  always_comb begin
    out_ctrl = live_ctrl;
    out_addr = live_addr;
    if (pend) begin
      out_ctrl       = hold_ctrl;
      out_ctrl.sel   = 1'b1;
      out_ctrl.trans = HTRANS_NONSEQ;
      out_addr       = hold_addr;
    end else if (!live_ctrl.sel) begin
      out_ctrl.trans = HTRANS_IDLE;
    end
  end
endmodule

// File: rtl/ahblite3_mem_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single memory slave: round-robin
// at transfer/burst boundaries, losing address phases are held and replayed.
module ahblite3_mem_arbiter
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_HSEL,
  input  logic [ADDR_W-1:0] m0_HADDR,
  input  logic [1:0]        m0_HTRANS,
  input  logic              m0_HWRITE,
  input  logic [2:0]        m0_HSIZE,
  input  logic [2:0]        m0_HBURST,
  input  logic [3:0]        m0_HPROT,
  input  logic              m0_HMASTLOCK,
  input  logic              m0_HREADY,
  input  logic [DATA_W-1:0] m0_HWDATA,
  output logic [DATA_W-1:0] m0_HRDATA,
  output logic              m0_HREADYOUT,
  output logic              m0_HRESP,
  input  logic              m1_HSEL,
  input  logic [ADDR_W-1:0] m1_HADDR,
  input  logic [1:0]        m1_HTRANS,
  input  logic              m1_HWRITE,
  input  logic [2:0]        m1_HSIZE,
  input  logic [2:0]        m1_HBURST,
  input  logic [3:0]        m1_HPROT,
  input  logic              m1_HMASTLOCK,
  input  logic              m1_HREADY,
  input  logic [DATA_W-1:0] m1_HWDATA,
  output logic [DATA_W-1:0] m1_HRDATA,
  output logic              m1_HREADYOUT,
  output logic              m1_HRESP,
  output logic              s_HSEL,
  output logic [ADDR_W-1:0] s_HADDR,
  output logic [1:0]        s_HTRANS,
  output logic              s_HWRITE,
  output logic [2:0]        s_HSIZE,
  output logic [2:0]        s_HBURST,
  output logic [3:0]        s_HPROT,
  output logic              s_HMASTLOCK,
  output logic              s_HREADY,
  output logic [DATA_W-1:0] s_HWDATA,
  input  logic [DATA_W-1:0] s_HRDATA,
  input  logic              s_HREADYOUT,
  input  logic              s_HRESP
);
  typedef enum logic [1:0] {DO_NONE, DO_M0, DO_M1} downer_e;

  logic                   owner, owner_nxt, rr_ptr, rr_nxt, gnt, keep, bus_free;
  downer_e                data_owner, data_nxt;
  logic      [1:0]        req, pend, hready;
  ahb_ctrl_t [1:0]        live_c, out_c;
  logic [1:0][ADDR_W-1:0] live_a, out_a;
  ahb_ctrl_t              own_c, s_c;

  assign live_c[0] = '{m0_HSEL, m0_HTRANS, m0_HWRITE, m0_HSIZE, m0_HBURST, m0_HPROT, m0_HMASTLOCK};
  assign live_c[1] = '{m1_HSEL, m1_HTRANS, m1_HWRITE, m1_HSIZE, m1_HBURST, m1_HPROT, m1_HMASTLOCK};
  assign live_a    = {m1_HADDR, m0_HADDR};
  assign hready    = {m1_HREADY, m0_HREADY};

  for (genvar i = 0; i < 2; i++) begin : g_hold
    ahblite3_arb_hold #(.ADDR_W(ADDR_W)) u_hold (
      .clk      (clk),
      .reset    (reset),
      .live_ctrl(live_c[i]),
      .live_addr(live_a[i]),
      .hready   (hready[i]),
      .grant    (gnt == 1'(i)),
      .s_ready  (s_HREADYOUT),
      .req      (req[i]),
      .pend     (pend[i]),
      .out_ctrl (out_c[i]),
      .out_addr (out_a[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      data_owner <= DO_NONE;
    end else begin
      owner      <= owner_nxt;
      rr_ptr     <= rr_nxt;
      data_owner <= data_nxt;
    end
  end

  always_comb begin
    own_c     = out_c[owner];
    // SEQ and BUSY both have bit 0 set: a burst in progress is never split.
    keep      = own_c.trans[0] || own_c.lock;
    bus_free  = s_HREADYOUT && !keep;
    gnt       = owner;
    rr_nxt    = rr_ptr;
    if (bus_free && (|req)) begin
      if (&req)       gnt = rr_ptr;
      else if (req[0]) gnt = 1'b0;
      else             gnt = 1'b1;
      rr_nxt = ~gnt;
    end
    owner_nxt = gnt;
    s_c       = reset ? out_c[gnt] : '0;
    data_nxt  = data_owner;
    if (s_HREADYOUT)
      data_nxt = !s_c.trans[1] ? DO_NONE : (gnt ? DO_M1 : DO_M0);
  end

  assign {s_HSEL, s_HTRANS, s_HWRITE, s_HSIZE, s_HBURST, s_HPROT, s_HMASTLOCK} = s_c;
  assign s_HADDR  = reset ? out_a[gnt] : '0;
  assign s_HREADY = s_HREADYOUT;
  assign s_HWDATA = (data_owner == DO_M1) ? m1_HWDATA : m0_HWDATA;

  // Data-phase response goes only to the master owning the data phase.
  always_comb begin
    m0_HRDATA    = (data_owner == DO_M0) ? s_HRDATA : '0;
    m1_HRDATA    = (data_owner == DO_M1) ? s_HRDATA : '0;
    m0_HRESP     = reset && (data_owner == DO_M0) && s_HRESP;
    m1_HRESP     = reset && (data_owner == DO_M1) && s_HRESP;
    m0_HREADYOUT = !reset || ((data_owner == DO_M0) ? s_HREADYOUT : !pend[0]);
    m1_HREADYOUT = !reset || ((data_owner == DO_M1) ? s_HREADYOUT : !pend[1]);
  end
endmodule

// File: tb/tb_ahblite3_mem_arbiter.sv
// Directed bench for the two-master memory arbiter; the slave side is driven
// cycle by cycle from the stimulus sequence.
module tb_ahblite3_mem_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

  logic clk = 1'b0, reset;
  logic m0_HSEL, m0_HWRITE, m0_HMASTLOCK, m0_HREADY, m0_HREADYOUT, m0_HRESP;
  logic m1_HSEL, m1_HWRITE, m1_HMASTLOCK, m1_HREADY, m1_HREADYOUT, m1_HRESP;
  logic [AW-1:0] m0_HADDR, m1_HADDR, s_HADDR;
  logic [1:0] m0_HTRANS, m1_HTRANS, s_HTRANS;
  logic [2:0] m0_HSIZE, m0_HBURST, m1_HSIZE, m1_HBURST, s_HSIZE, s_HBURST;
  logic [3:0] m0_HPROT, m1_HPROT, s_HPROT;
  logic [DW-1:0] m0_HWDATA, m0_HRDATA, m1_HWDATA, m1_HRDATA, s_HWDATA, s_HRDATA;
  logic s_HSEL, s_HWRITE, s_HMASTLOCK, s_HREADY, s_HREADYOUT, s_HRESP;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  assign m0_HREADY = m0_HREADYOUT;
  assign m1_HREADY = m1_HREADYOUT;

  ahblite3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_HSEL(m0_HSEL), .m0_HADDR(m0_HADDR), .m0_HTRANS(m0_HTRANS), .m0_HWRITE(m0_HWRITE),
    .m0_HSIZE(m0_HSIZE), .m0_HBURST(m0_HBURST), .m0_HPROT(m0_HPROT), .m0_HMASTLOCK(m0_HMASTLOCK),
    .m0_HREADY(m0_HREADY), .m0_HWDATA(m0_HWDATA), .m0_HRDATA(m0_HRDATA),
    .m0_HREADYOUT(m0_HREADYOUT), .m0_HRESP(m0_HRESP),
    .m1_HSEL(m1_HSEL), .m1_HADDR(m1_HADDR), .m1_HTRANS(m1_HTRANS), .m1_HWRITE(m1_HWRITE),
    .m1_HSIZE(m1_HSIZE), .m1_HBURST(m1_HBURST), .m1_HPROT(m1_HPROT), .m1_HMASTLOCK(m1_HMASTLOCK),
    .m1_HREADY(m1_HREADY), .m1_HWDATA(m1_HWDATA), .m1_HRDATA(m1_HRDATA),
    .m1_HREADYOUT(m1_HREADYOUT), .m1_HRESP(m1_HRESP),
    .s_HSEL(s_HSEL), .s_HADDR(s_HADDR), .s_HTRANS(s_HTRANS), .s_HWRITE(s_HWRITE),
    .s_HSIZE(s_HSIZE), .s_HBURST(s_HBURST), .s_HPROT(s_HPROT), .s_HMASTLOCK(s_HMASTLOCK),
    .s_HREADY(s_HREADY), .s_HWDATA(s_HWDATA), .s_HRDATA(s_HRDATA),
    .s_HREADYOUT(s_HREADYOUT), .s_HRESP(s_HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int m, input logic [1:0] tr, input logic [AW-1:0] a,
                     input logic w, input logic [2:0] b);
    if (m == 0) begin
      m0_HSEL = (tr != IDLE); m0_HTRANS = tr; m0_HADDR = a; m0_HWRITE = w; m0_HBURST = b;
    end else begin
      m1_HSEL = (tr != IDLE); m1_HTRANS = tr; m1_HADDR = a; m1_HWRITE = w; m1_HBURST = b;
    end
  endtask

  initial begin
    reset = 1'b0;
    drv(0, IDLE, '0, 1'b0, 3'b000); drv(1, IDLE, '0, 1'b0, 3'b000);
    m0_HSIZE = 3'b010; m1_HSIZE = 3'b010; m0_HPROT = 4'h3; m1_HPROT = 4'h3;
    m0_HMASTLOCK = 1'b0; m1_HMASTLOCK = 1'b0; m0_HWDATA = '0; m1_HWDATA = '0;
    s_HRDATA = '0; s_HREADYOUT = 1'b1; s_HRESP = 1'b0;
    tick(); tick();
    #4;
    chk("rst_s_htrans", s_HTRANS, IDLE);
    chk("rst_s_hsel", s_HSEL, 0);
    chk("rst_s_haddr", s_HADDR, 0);
    chk("rst_m0_rdy", m0_HREADYOUT, 1);
    chk("rst_m1_rdy", m1_HREADYOUT, 1);
    chk("rst_m0_resp", m0_HRESP, 0);
    reset = 1'b1;
    tick();

    // Contest with rr_ptr at m0: m0 first, m1 held and replayed.
    drv(0, NSEQ, 24'h000100, 1'b0, 3'b000); drv(1, NSEQ, 24'h000200, 1'b0, 3'b000);
    #4;
    chk("ct_first_addr", s_HADDR, 24'h000100);
    chk("ct_m1_rdy_c1", m1_HREADYOUT, 1);
    tick();
    drv(0, IDLE, '0, 1'b0, 3'b000); drv(1, IDLE, 24'h000999, 1'b0, 3'b000);
    s_HRDATA = 32'h11110100;
    #4;
    chk("ct_m1_stall", m1_HREADYOUT, 0);
    chk("ct_m0_rdata", m0_HRDATA, 32'h11110100);
    chk("ct_replay_addr", s_HADDR, 24'h000200);
    chk("ct_replay_trans", s_HTRANS, NSEQ);
    tick();
    s_HRDATA = 32'h22220200;
    #4;
    chk("ct_m1_rdata", m1_HRDATA, 32'h22220200);
    chk("ct_m1_rdy", m1_HREADYOUT, 1);
    chk("ct_bus_idle", s_HTRANS, IDLE);
    tick();
    // rr_ptr is back at m0: a second contest is won by m0 again.
    drv(0, NSEQ, 24'h000300, 1'b0, 3'b000); drv(1, NSEQ, 24'h000400, 1'b0, 3'b000);
    #4;
    chk("rr_m0_wins", s_HADDR, 24'h000300);
    tick();
    drv(0, IDLE, '0, 1'b0, 3'b000); drv(1, IDLE, '0, 1'b0, 3'b000);
    #4;
    chk("rr_replay", s_HADDR, 24'h000400);
    chk("rr_m1_stall", m1_HREADYOUT, 0);
    tick();
    #4;
    chk("rr_m1_done", m1_HREADYOUT, 1);
    tick();

    // m1 INCR4 write; m0 arrives at beat 2 and waits for the burst end.
    drv(1, NSEQ, 24'h000040, 1'b1, 3'b011);
    #4;
    chk("b4_beat1", s_HADDR, 24'h000040);
    chk("b4_write", s_HWRITE, 1);
    tick();
    drv(1, SEQ, 24'h000044, 1'b1, 3'b011); m1_HWDATA = 32'hD0D0D000;
    drv(0, NSEQ, 24'h000500, 1'b0, 3'b000);
    #4;
    chk("b4_beat2", s_HADDR, 24'h000044);
    chk("b4_wdata0", s_HWDATA, 32'hD0D0D000);
    tick();
    drv(1, SEQ, 24'h000048, 1'b1, 3'b011); m1_HWDATA = 32'hD0D0D001;
    drv(0, IDLE, '0, 1'b0, 3'b000);
    #4;
    chk("b4_beat3", s_HADDR, 24'h000048);
    chk("b4_m0_stall", m0_HREADYOUT, 0);
    tick();
    drv(1, SEQ, 24'h00004C, 1'b1, 3'b011); m1_HWDATA = 32'hD0D0D002;
    #4;
    chk("b4_beat4", s_HADDR, 24'h00004C);
    chk("b4_beat4_tr", s_HTRANS, SEQ);
    tick();
    drv(1, IDLE, '0, 1'b0, 3'b000); m1_HWDATA = 32'hD0D0D003;
    #4;
    chk("b4_m0_handoff", s_HADDR, 24'h000500);
    chk("b4_wdata3", s_HWDATA, 32'hD0D0D003);
    chk("b4_m0_still", m0_HREADYOUT, 0);
    tick();
    s_HRDATA = 32'h33330500;
    #4;
    chk("b4_m0_rdata", m0_HRDATA, 32'h33330500);
    chk("b4_m0_rdy", m0_HREADYOUT, 1);
    tick();

    // Two-cycle ERROR on m0 while m1 gets held.
    drv(0, NSEQ, 24'h000600, 1'b0, 3'b000);
    #4;
    chk("er_addr", s_HADDR, 24'h000600);
    tick();
    drv(0, IDLE, '0, 1'b0, 3'b000); drv(1, NSEQ, 24'h000700, 1'b0, 3'b000);
    s_HREADYOUT = 1'b0; s_HRESP = 1'b1;
    #4;
    chk("er1_m0_resp", m0_HRESP, 1);
    chk("er1_m0_rdy", m0_HREADYOUT, 0);
    chk("er1_m1_resp", m1_HRESP, 0);
    chk("er1_m1_rdy", m1_HREADYOUT, 1);
    tick();
    drv(1, IDLE, '0, 1'b0, 3'b000);
    s_HREADYOUT = 1'b1;
    #4;
    chk("er2_m0_resp", m0_HRESP, 1);
    chk("er2_m0_rdy", m0_HREADYOUT, 1);
    chk("er2_m1_resp", m1_HRESP, 0);
    chk("er2_m1_stall", m1_HREADYOUT, 0);
    chk("er2_m1_replay", s_HADDR, 24'h000700);
    tick();
    s_HRESP = 1'b0;
    #4;
    chk("er_m1_done", m1_HREADYOUT, 1);
    chk("er_m0_okay", m0_HRESP, 0);
    tick();

    // Reset during beat 5 of an m0 INCR8 with m1 pending.
    drv(0, NSEQ, 24'h000800, 1'b0, 3'b101);
    #4;
    chk("r8_beat1", s_HADDR, 24'h000800);
    tick();
    drv(0, SEQ, 24'h000804, 1'b0, 3'b101);
    tick();
    drv(0, SEQ, 24'h000808, 1'b0, 3'b101); drv(1, NSEQ, 24'h000900, 1'b0, 3'b000);
    #4;
    chk("r8_beat3", s_HADDR, 24'h000808);
    tick();
    drv(0, SEQ, 24'h00080C, 1'b0, 3'b101); drv(1, IDLE, '0, 1'b0, 3'b000);
    #4;
    chk("r8_m1_stall", m1_HREADYOUT, 0);
    tick();
    drv(0, SEQ, 24'h000810, 1'b0, 3'b101);
    reset = 1'b0;
    tick();
    drv(0, SEQ, 24'h000814, 1'b0, 3'b101);
    #4;
    chk("r8_rst_trans", s_HTRANS, IDLE);
    chk("r8_rst_m0_rdy", m0_HREADYOUT, 1);
    chk("r8_rst_m1_rdy", m1_HREADYOUT, 1);
    tick();
    reset = 1'b1;
    drv(0, IDLE, '0, 1'b0, 3'b000);
    #4;
    chk("r8_no_replay", s_HTRANS, IDLE);
    chk("r8_m1_free", m1_HREADYOUT, 1);
    chk("r8_addr0", s_HADDR, 0);
    tick();
    #4;
    chk("r8_no_replay2", s_HTRANS, IDLE);
    tick();

    // Uncontested m0 single read: zero added latency, slave wait passed through.
    drv(0, NSEQ, 24'h000100, 1'b0, 3'b000);
    #4;
    chk("sg_addr", s_HADDR, 24'h000100);
    chk("sg_trans", s_HTRANS, NSEQ);
    tick();
    drv(0, IDLE, '0, 1'b0, 3'b000);
    s_HREADYOUT = 1'b0;
    #4;
    chk("sg_wait", m0_HREADYOUT, 0);
    tick();
    s_HREADYOUT = 1'b1; s_HRDATA = 32'h5555AAAA;
    #4;
    chk("sg_rdata", m0_HRDATA, 32'h5555AAAA);
    chk("sg_rdy", m0_HREADYOUT, 1);
    chk("sg_m1_rdata", m1_HRDATA, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
